// File: rtl/issue_scoreboard.sv
// Register/structural hazard scheduler for the dual-slot (upper/lower) decode stage.
// Keeps a per-GPR countdown of cycles until an in-flight result becomes readable and a
// busy countdown for the shared non-pipelined Fdiv/Fsqrt unit. From these it raises a
// combinational interlock that holds the current bundle in decode.
//
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   inst_valid, flush             decode holds a bundle / decode is discarding it
//   u_* / l_*                     per-slot sources, use mask {s,b,a}, rd, latency, div class
//   interlock, issue              same-cycle hold / accept for the bundle in decode
//   pending                       bit r set while GPR r still has a countdown running
//   div_busy                      divider countdown running
//   stall_cycles                  saturating count of interlocked cycles
module issue_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned LAT_W   = 4,
  parameter int unsigned DIV_LAT = 12,
  localparam int unsigned IdxW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inst_valid,
  input  logic             flush,
  input  logic [IdxW-1:0]  u_src_a,
  input  logic [IdxW-1:0]  u_src_b,
  input  logic [IdxW-1:0]  u_src_s,
  input  logic [2:0]       u_use,
  input  logic [IdxW-1:0]  u_rd,
  input  logic [LAT_W-1:0] u_lat,
  input  logic             u_div,
  input  logic [IdxW-1:0]  l_src_a,
  input  logic [IdxW-1:0]  l_src_b,
  input  logic [IdxW-1:0]  l_src_s,
  input  logic [2:0]       l_use,
  input  logic [IdxW-1:0]  l_rd,
  input  logic [LAT_W-1:0] l_lat,
  input  logic             l_div,
  output logic             interlock,
  output logic             issue,
  output logic [NREG-1:0]  pending,
  output logic             div_busy,
  output logic [31:0]      stall_cycles
);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [LAT_W-1:0] div_q, div_d;
  logic [31:0]      stall_q, stall_d;
  logic             raw_hit, waw_hit, div_hit;

  // Hazard detection and issue decision.
  always_comb begin
    raw_hit = (u_use[0] && (cnt_q[u_src_a] != '0)) ||
              (u_use[1] && (cnt_q[u_src_b] != '0)) ||
              (u_use[2] && (cnt_q[u_src_s] != '0)) ||
              (l_use[0] && (cnt_q[l_src_a] != '0)) ||
              (l_use[1] && (cnt_q[l_src_b] != '0)) ||
              (l_use[2] && (cnt_q[l_src_s] != '0));
    // A new write must not land before an older, longer-latency write to the same rd.
    waw_hit = ((u_lat != '0) && (cnt_q[u_rd] > u_lat)) ||
              ((l_lat != '0) && (cnt_q[l_rd] > l_lat));
    div_hit = (u_div || l_div) && (div_q != '0);
    interlock = inst_valid && !flush && (raw_hit || waw_hit || div_hit);
    issue     = inst_valid && !flush && !interlock;
  end

  // Countdown next state: an issuing write reloads, otherwise count down to zero.
  always_comb begin
    logic u_wr, l_wr;
    u_wr = 1'b0;
    l_wr = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      u_wr = issue && (u_lat != '0) && (u_rd == IdxW'(r));
      l_wr = issue && (l_lat != '0) && (l_rd == IdxW'(r));
      if (u_wr && l_wr) begin
        cnt_d[r] = (u_lat > l_lat) ? u_lat : l_lat;
      end else if (u_wr) begin
        cnt_d[r] = u_lat;
      end else if (l_wr) begin
        cnt_d[r] = l_lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  always_comb begin
    if (issue && (u_div || l_div)) begin
      div_d = LAT_W'(DIV_LAT);
    end else if (div_q != '0) begin
      div_d = div_q - LAT_W'(1);
    end else begin
      div_d = div_q;
    end
    stall_d = (interlock && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      div_q   <= '0;
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      div_q   <= div_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NREG; r++) begin
      pending[r] = (cnt_q[r] != '0);
    end
  end

  assign div_busy     = (div_q != '0);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_valid, flush;
  logic [4:0]  u_src_a, u_src_b, u_src_s, u_rd;
  logic [2:0]  u_use;
  logic [3:0]  u_lat;
  logic        u_div;
  logic [4:0]  l_src_a, l_src_b, l_src_s, l_rd;
  logic [2:0]  l_use;
  logic [3:0]  l_lat;
  logic        l_div;
  logic        interlock, issue, div_busy;
  logic [31:0] pending, stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.NREG(32), .LAT_W(4), .DIV_LAT(12)) dut (
    .clk(clk), .rstn(rstn), .inst_valid(inst_valid), .flush(flush),
    .u_src_a(u_src_a), .u_src_b(u_src_b), .u_src_s(u_src_s), .u_use(u_use),
    .u_rd(u_rd), .u_lat(u_lat), .u_div(u_div),
    .l_src_a(l_src_a), .l_src_b(l_src_b), .l_src_s(l_src_s), .l_use(l_use),
    .l_rd(l_rd), .l_lat(l_lat), .l_div(l_div),
    .interlock(interlock), .issue(issue), .pending(pending), .div_busy(div_busy),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic        v, fl;
    logic [2:0]  uuse;
    logic [4:0]  ua, urd;
    logic [3:0]  ulat;
    logic        udiv;
    logic [2:0]  luse;
    logic [4:0]  la, lrd;
    logic [3:0]  llat;
    logic        ldiv;
    logic        e_il, e_iss;
    logic [31:0] e_pend;
    logic        e_div;
    logic [31:0] e_stall;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  // Source b/s indices are derived as a+1 / a+2 so use-mask bits select distinct registers.
  function automatic vec_t mk(input logic v, fl, input logic [2:0] uuse, input logic [4:0] ua,
                              urd, input logic [3:0] ulat, input logic udiv,
                              input logic [2:0] luse, input logic [4:0] la, lrd,
                              input logic [3:0] llat, input logic ldiv, e_il, e_iss,
                              input logic [31:0] e_pend, input logic e_div,
                              input logic [31:0] e_stall);
    vec_t t;
    t.v = v; t.fl = fl; t.uuse = uuse; t.ua = ua; t.urd = urd; t.ulat = ulat; t.udiv = udiv;
    t.luse = luse; t.la = la; t.lrd = lrd; t.llat = llat; t.ldiv = ldiv;
    t.e_il = e_il; t.e_iss = e_iss; t.e_pend = e_pend; t.e_div = e_div; t.e_stall = e_stall;
    return t;
  endfunction

  function automatic vec_t idle(input logic [31:0] e_pend, input logic e_div,
                                input logic [31:0] e_stall);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pend, e_div, e_stall);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    inst_valid = 0; flush = 0;
    u_src_a = 0; u_src_b = 0; u_src_s = 0; u_use = 0; u_rd = 0; u_lat = 0; u_div = 0;
    l_src_a = 0; l_src_b = 0; l_src_s = 0; l_use = 0; l_rd = 0; l_lat = 0; l_div = 0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    inst_valid = v.v; flush = v.fl;
    u_use = v.uuse; u_src_a = v.ua; u_src_b = v.ua + 5'd1; u_src_s = v.ua + 5'd2;
    u_rd = v.urd; u_lat = v.ulat; u_div = v.udiv;
    l_use = v.luse; l_src_a = v.la; l_src_b = v.la + 5'd1; l_src_s = v.la + 5'd2;
    l_rd = v.lrd; l_lat = v.llat; l_div = v.ldiv;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    chk({tag, ".interlock"}, 32'(interlock), 32'(e.e_il));
    chk({tag, ".issue"}, 32'(issue), 32'(e.e_iss));
    @(posedge clk);
    #1;
    chk({tag, ".pending"}, pending, e.e_pend);
    chk({tag, ".div_busy"}, 32'(div_busy), 32'(e.e_div));
    chk({tag, ".stall"}, stall_cycles, e.e_stall);
  endtask

  initial begin
    int st;
    rstn = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pending", pending, 0);
    chk("reset.div_busy", 32'(div_busy), 0);
    chk("reset.stall", stall_cycles, 0);
    chk("reset.interlock", 32'(interlock), 0);
    @(negedge clk);
    rstn = 1;

    // Dependent chain on r5 (lat 3): three stalls then issue.
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 32'h20, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 32'h20, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 32'h0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 32'h0, 0, 3));
    // Independent bundle reads r6/r7 and writes r8 while r5 is in flight.
    tbl.push_back(mk(1, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 3));
    tbl.push_back(mk(1, 0, 3, 6, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h120, 0, 3));
    tbl.push_back(idle(32'h20, 0, 3));
    tbl.push_back(idle(32'h0, 0, 3));
    // WAW: r9 lat 4, then a lat-2 write to r9 waits until the count falls to 2.
    tbl.push_back(mk(1, 0, 0, 0, 9, 4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 9, 2, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 9, 2, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 9, 2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 5));
    tbl.push_back(idle(32'h200, 0, 5));
    tbl.push_back(idle(32'h0, 0, 5));
    // Flush suppresses the interlock and the stall count but not the countdown.
    tbl.push_back(mk(1, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, 0, 5));
    tbl.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0, 5));
    tbl.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 6));
    // Same rd in both slots takes the max latency (5); a lat-4 write to r10 then waits once.
    tbl.push_back(mk(1, 0, 0, 0, 10, 2, 0, 0, 0, 10, 5, 0, 0, 1, 32'h400, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 10, 4, 0, 0, 0, 0, 0, 0, 1, 0, 32'h400, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 10, 4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 7));
    tbl.push_back(idle(32'h400, 0, 7));
    tbl.push_back(idle(32'h400, 0, 7));
    tbl.push_back(idle(32'h400, 0, 7));
    tbl.push_back(idle(32'h0, 0, 7));
    // Lower slot writes r12; upper reads it through the s operand only.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0, 1, 32'h1000, 0, 7));
    tbl.push_back(mk(1, 0, 4, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 8));
    tbl.push_back(mk(1, 0, 4, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 8));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Divider: 12 busy cycles; a non-div bundle mid-stall issues immediately.
    st = 8;
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, st), "div.start");
    for (int i = 1; i <= 13; i++) begin
      if (i == 6) begin
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, st), $sformatf("div.nd%0d", i));
      end else if (i <= 12) begin
        st++;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, (i < 12), st),
              $sformatf("div.stall%0d", i));
      end else begin
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, st), "div.issue");
      end
    end
    for (int k = 1; k <= 12; k++) begin
      apply(idle(0, (k < 12), st), $sformatf("div.drain%0d", k));
    end

    // Reset mid-operation clears r4 (lat 7) and the divider.
    apply(mk(1, 0, 0, 0, 4, 7, 1, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, st), "rst.prod");
    apply(idle(32'h10, 1, st), "rst.wait");
    @(negedge clk);
    rstn = 0;
    @(posedge clk);
    #1;
    chk("rst.pending", pending, 0);
    chk("rst.div_busy", 32'(div_busy), 0);
    chk("rst.stall", stall_cycles, 0);
    rstn = 1;
    apply(mk(1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0), "rst.reader");
    for (int k = 1; k <= 12; k++) begin
      apply(idle(0, (k < 12), 0), $sformatf("rst.drain%0d", k));
    end

    // Saturation: preload near the top, then keep stalling.
    @(negedge clk);
    force dut.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_q;
    apply(mk(1, 0, 0, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 32'hFFFF_FFFE), "sat.prod");
    for (int i = 1; i <= 4; i++) begin
      apply(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i < 4) ? 32'h4 : 32'h0, 0,
               32'hFFFF_FFFF), $sformatf("sat.stall%0d", i));
    end
    apply(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF), "sat.issue");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-hazard and structural-hazard scheduler for the dual-slot (upper/lower) decode stage.
- Tracks a per-GPR countdown of cycles until each in-flight result is readable. Combinationally raises `interlock` to hold the current bundle in decode.
- Tracks busy time of the shared non-pipelined Fdiv/Fsqrt unit.
- Sits beside decode: consumes decoded register fields and per-slot latency/unit class; drives decode's `interlock` input.

Parameters:
- NREG, 32, number of tracked GPRs (index width clog2(NREG)).
- LAT_W, 4, width of the per-register countdown and of the latency inputs.
- DIV_LAT, 12, cycles the Fdiv/Fsqrt unit stays busy after issue (1..2^LAT_W-1).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- inst_valid  in  1  decode holds a real bundle this cycle
- flush  in  1  decode is discarding its bundle (branch taken); no issue this cycle
- u_src_a / u_src_b / u_src_s  in  5 each  upper source register indices
- u_use  in  3  upper source-used mask {s,b,a}
- u_rd  in  5  upper destination register
- u_lat  in  LAT_W  upper result latency; 0 = no register write
- u_div  in  1  upper is Fdiv/Fsqrt
- l_src_a / l_src_b / l_src_s, l_use, l_rd, l_lat, l_div  in  same widths  lower-slot equivalents
- interlock  out  1  hold bundle in decode (combinational)
- issue  out  1  bundle accepted this cycle (combinational)
- pending  out  NREG  bit r = cnt[r] != 0 (registered)
- div_busy  out  1  divider busy counter != 0 (registered)
- stall_cycles  out  32  saturating count of interlocked cycles

Behaviour:
- Reset (rstn=0 at posedge): all cnt[r]=0, div counter=0, stall_cycles=0. Hence pending=0, div_busy=0, interlock=0 (absent inputs).
- raw_hit = any slot s, operand k with use[k]=1 and cnt[src_k] != 0.
- waw_hit = any slot with lat != 0 and cnt[rd] > lat (unsigned). Enforces in-order writeback.
- div_hit = (u_div | l_div) and div counter != 0.
- interlock = inst_valid & ~flush & (raw_hit | waw_hit | div_hit).
- issue = inst_valid & ~flush & ~interlock.
- Each posedge, for every r: if an issuing slot writes r (issue & lat != 0 & rd == r), cnt[r] <= that lat. Else if cnt[r] != 0, cnt[r] <= cnt[r]-1. Issue load beats decrement.
- Both slots write the same rd in one issuing bundle: cnt[rd] <= max(u_lat, l_lat).
- Semantics: a result issued with lat=L stalls dependents for exactly L subsequent cycles. The first dependent bundle issues L+1 cycles after the producer.
- Divider: on issue with (u_div | l_div), div counter <= DIV_LAT; otherwise it decrements toward 0.
  - Both slots u_div & l_div in one bundle is a compiler constraint; the counter loads DIV_LAT once, and this case is not checked.
- Intra-bundle lower-reads-upper-rd dependencies are a compiler constraint, not checked here.
- flush=1 suppresses issue and stall counting only. Counters of already-issued producers keep decrementing.
- inst_valid=0: interlock=0, issue=0, counters still decrement.
- stall_cycles increments when interlock=1; it saturates at 32'hFFFF_FFFF with no wrap.
- Reset mid-operation clears all counters immediately. The next cycle issues with no hazards regardless of prior in-flight ops.
- Latency: interlock/issue are same-cycle combinational. pending and div_busy reflect state after the last posedge.

Test Plan:
- Dependent chain: issue upper rd=5 lat=3, next bundle uses l_src_a=5 -> interlock=1 for 3 cycles, issue on cycle 4; stall_cycles=3.
- Independent bundle: cnt[5]=3, bundle uses regs 6,7 and writes rd=8 lat=1 -> issue=1 in the same cycle; pending[8]=1 next cycle.
- WAW: cnt[9]=4, bundle writes rd=9 lat=2 -> interlock for 2 cycles (until cnt[9]=2), then issue and cnt[9]<=2.
- Divider: DIV_LAT=12, issue u_div, then a bundle with l_div every cycle -> 12 stall cycles, issue on the 13th; a non-div bundle mid-stall issues immediately.
- Flush/reset: cnt[3]=2 with a bundle reading r3 and flush=1 -> interlock=0, issue=0, stall_cycles unchanged. Assert rstn=0 with cnt[4]=7 -> next cycle pending=0 and a bundle reading r4 issues.
- Same-rd bundle: u_rd=l_rd=10, u_lat=2, l_lat=5 -> cnt[10]=5; stall_cycles preloaded near saturation stays at FFFF_FFFF under continued stalls.
